// File: rtl/line_drawer.sv
// line_drawer: Bresenham rasteriser, one on-screen pixel per valid/ready handshake.
module line_drawer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] x0,
  input  logic [8:0] y0,
  input  logic [9:0] x1,
  input  logic [8:0] y1,
  output logic [9:0] pixel_x,
  output logic [8:0] pixel_y,
  output logic       pixel_valid,
  input  logic       pixel_ready,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;
  state_t state_q, state_d;
  logic [9:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [9:0] a_q, a_d, b_q, b_d, aend_q, aend_d, dx_q, dx_d, dy_q, dy_d;
  logic steep_q, steep_d, yneg_q, yneg_d;
  logic signed [11:0] err_q, err_d, err_s;
  logic [9:0] adx, ady, sa0, sb0, sa1, sb1, ua0, ub0, ua1, ub1, ddx, px, py;
  logic steep_s, swap, visible, advance;
  // Setup datapath: fold octants into a left-to-right shallow walk along axis a
  assign adx = x1_q >= x0_q ? x1_q - x0_q : x0_q - x1_q;
  assign ady = y1_q >= y0_q ? y1_q - y0_q : y0_q - y1_q;
  assign steep_s = ady > adx;
  assign sa0 = steep_s ? y0_q : x0_q;
  assign sb0 = steep_s ? x0_q : y0_q;
  assign sa1 = steep_s ? y1_q : x1_q;
  assign sb1 = steep_s ? x1_q : y1_q;
  assign swap = sa0 > sa1;
  assign ua0 = swap ? sa1 : sa0;
  assign ub0 = swap ? sb1 : sb0;
  assign ua1 = swap ? sa0 : sa1;
  assign ub1 = swap ? sb0 : sb1;
  assign ddx = ua1 - ua0;
  assign px = steep_q ? b_q : a_q;
  assign py = steep_q ? a_q : b_q;
  assign pixel_x = px;
  assign pixel_y = py[8:0];
  assign visible = px < 10'd640 && py < 10'd480;
  assign pixel_valid = state_q == DRAW && visible;
  // Off-screen pixels step through without waiting on the framebuffer
  assign advance = state_q == DRAW && (!visible || pixel_ready);
  assign busy = state_q == SETUP || state_q == DRAW;
  assign done = state_q == DONE;
  assign err_s = err_q + $signed({2'b00, dy_q});
  always_comb begin
    state_d = state_q;
    x0_d = x0_q;
    y0_d = y0_q;
    x1_d = x1_q;
    y1_d = y1_q;
    a_d = a_q;
    b_d = b_q;
    aend_d = aend_q;
    dx_d = dx_q;
    dy_d = dy_q;
    steep_d = steep_q;
    yneg_d = yneg_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        x0_d = x0;
        y0_d = {1'b0, y0};
        x1_d = x1;
        y1_d = {1'b0, y1};
      end
      SETUP: begin
        state_d = DRAW;
        steep_d = steep_s;
        a_d = ua0;
        b_d = ub0;
        aend_d = ua1;
        dx_d = ddx;
        dy_d = ub0 < ub1 ? ub1 - ub0 : ub0 - ub1;
        yneg_d = !(ub0 < ub1);
        err_d = -$signed({3'b000, ddx[9:1]});
      end
      DRAW: if (advance) begin
        if (a_q == aend_q) state_d = DONE;
        else begin
          a_d = a_q + 10'd1;
          b_d = err_s >= 0 ? (yneg_q ? b_q - 10'd1 : b_q + 10'd1) : b_q;
          err_d = err_s >= 0 ? err_s - $signed({2'b00, dx_q}) : err_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x0_q <= '0;
      y0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      a_q <= '0;
      b_q <= '0;
      aend_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
      steep_q <= 1'b0;
      yneg_q <= 1'b0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q <= x0_d;
      y0_q <= y0_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
      a_q <= a_d;
      b_q <= b_d;
      aend_q <= aend_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      steep_q <= steep_d;
      yneg_q <= yneg_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_line_drawer.sv
// tb_line_drawer: table vectors, hand sequences and random lines against a pixel-list model.
module tb_line_drawer;
  logic clk = 1'b0;
  logic reset, start, pixel_ready;
  logic [9:0] x0, x1, pixel_x;
  logic [8:0] y0, y1, pixel_y;
  logic pixel_valid, busy, done;
  line_drawer dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {int x; int y;} pt_t;
  typedef struct {int x0; int y0; int x1; int y1; int mode; int cnt; int fx; int fy; int lx; int ly; int lat;} vec_t;
  pt_t exp_q[$], got_q[$];
  int checks = 0, failures = 0;
  int done_cnt, done_cyc, busy_cnt, first_cyc, hold_obs;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction
  // Whole-line reference: list of on-screen pixels in emission order
  function automatic void model(input int ax0, input int ay0, input int ax1, input int ay1);
    int t, dx, dy, err, b, ys, px, py;
    bit st;
    exp_q.delete();
    st = iabs(ay1 - ay0) > iabs(ax1 - ax0);
    if (st) begin
      t = ax0; ax0 = ay0; ay0 = t;
      t = ax1; ax1 = ay1; ay1 = t;
    end
    if (ax0 > ax1) begin
      t = ax0; ax0 = ax1; ax1 = t;
      t = ay0; ay0 = ay1; ay1 = t;
    end
    dx = ax1 - ax0;
    dy = iabs(ay1 - ay0);
    ys = ay0 < ay1 ? 1 : -1;
    err = -(dx / 2);
    b = ay0;
    for (int a = ax0; a <= ax1; a++) begin
      px = st ? b : a;
      py = st ? a : b;
      if (px < 640 && py < 480) exp_q.push_back('{px, py});
      err += dy;
      if (err >= 0) begin
        b += ys;
        err -= dx;
      end
    end
  endfunction
  // mode 0: ready always high, 1: random ready, 2: stall three cycles at pixel (1,1)
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1, input int mode);
    int hold = 0, mi = -1;
    bit fin = 0;
    got_q.delete();
    done_cnt = 0; done_cyc = 0; busy_cnt = 0; first_cyc = 0; hold_obs = 0;
    model(ax0, ay0, ax1, ay1);
    @(negedge clk);
    x0 = 10'(ax0); y0 = 9'(ay0); x1 = 10'(ax1); y1 = 9'(ay1);
    start = 1'b1;
    pixel_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x0 = 10'($urandom); y0 = 9'($urandom); x1 = 10'($urandom); y1 = 9'($urandom);
    for (int c = 1; c <= 20000 && !fin; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (pixel_valid && first_cyc == 0) first_cyc = c;
      if (done) begin
        done_cnt++;
        done_cyc = c;
        fin = 1;
      end
      if (mode == 2 && pixel_valid && pixel_x == 10'd1 && pixel_y == 9'd1) hold_obs++;
      pixel_ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(3) != 0)
                  : !(pixel_valid && pixel_x == 10'd1 && pixel_y == 9'd1 && hold < 3);
      if (mode == 2 && !pixel_ready) hold++;
      if (pixel_valid && pixel_ready) got_q.push_back('{int'(pixel_x), int'(pixel_y)});
    end
    chk("done_seen", int'(fin), 1);
    if (fin) begin
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
      chk("idle_not_busy", int'(busy), 0);
    end
    chk("pixel_count_vs_model", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size() && mi < 0; i++)
      if (got_q[i] != exp_q[i]) mi = i;
    chk("pixel_seq_first_bad_index", mi, -1);
    if (mi >= 0) $display("  index %0d: got (%0d,%0d) expected (%0d,%0d)", mi,
                          got_q[mi].x, got_q[mi].y, exp_q[mi].x, exp_q[mi].y);
  endtask
  vec_t vecs[5];
  initial begin
    int steps, dseen, k;
    vecs[0] = '{0, 0, 4, 0, 0, 5, 0, 0, 4, 0, 7};
    vecs[1] = '{3, 7, 0, 0, 0, 8, 0, 0, 3, 7, 10};
    vecs[2] = '{10, 20, 10, 20, 0, 1, 10, 20, 10, 20, 3};
    vecs[3] = '{0, 0, 3, 3, 2, 4, 0, 0, 3, 3, 9};
    vecs[4] = '{50, 100, 100, 480, 0, 380, 50, 100, -1, -1, 383};
    reset = 1'b1; start = 1'b0; pixel_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_pixel_x", int'(pixel_x), 0);
    chk("rst_pixel_y", int'(pixel_y), 0);
    chk("rst_valid", int'(pixel_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    foreach (vecs[i]) begin
      run_line(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].mode);
      chk("vec_valid_count", got_q.size(), vecs[i].cnt);
      if (got_q.size() > 0) begin
        chk("vec_first_x", got_q[0].x, vecs[i].fx);
        chk("vec_first_y", got_q[0].y, vecs[i].fy);
        if (vecs[i].lx >= 0) begin
          chk("vec_last_x", got_q[$].x, vecs[i].lx);
          chk("vec_last_y", got_q[$].y, vecs[i].ly);
        end
      end
      chk("vec_done_cycle", done_cyc, vecs[i].lat);
      chk("vec_busy_cycles", busy_cnt, vecs[i].lat - 1);
      chk("vec_done_pulses", done_cnt, 1);
      chk("vec_first_pixel_cycle", first_cyc, 2);
      if (vecs[i].mode == 2) chk("stall_hold_cycles", hold_obs, 4);
    end
    // Reset in the middle of a long horizontal line
    @(negedge clk);
    x0 = 10'd0; y0 = 9'd0; x1 = 10'd100; y1 = 9'd0; start = 1'b1; pixel_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(pixel_valid && pixel_x == 10'd40) && k < 200);
    chk("reach_pixel_40", int'(pixel_x), 40);
    reset = 1'b1;
    #1;
    chk("midrst_pixel_x", int'(pixel_x), 0);
    chk("midrst_valid", int'(pixel_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    dseen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) dseen++;
    end
    chk("no_activity_after_reset", dseen, 0);
    run_line(0, 0, 5, 0, 0);
    chk("post_reset_first_x", got_q.size() > 0 ? got_q[0].x : -1, 0);
    // Random endpoints across and beyond the visible area
    for (int i = 0; i < 12; i++) begin
      int rx0, ry0, rx1, ry1;
      rx0 = $urandom_range(700); ry0 = $urandom_range(511);
      rx1 = $urandom_range(700); ry1 = $urandom_range(511);
      run_line(rx0, ry0, rx1, ry1, i % 2);
      chk("rand_done_pulses", done_cnt, 1);
      if (i % 2 == 0) begin
        steps = (iabs(rx1 - rx0) > iabs(ry1 - ry0) ? iabs(rx1 - rx0) : iabs(ry1 - ry0)) + 1;
        chk("rand_done_cycle", done_cyc, steps + 2);
        chk("rand_busy_cycles", busy_cnt, steps + 1);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
